// File: rtl/m_cp0_exc.sv
// M-stage coprocessor 0: SR/Cause/EPC registers, exception and interrupt decision,
// and the flush/redirect request to the pipeline.
module m_cp0_exc #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] SR_WMASK   = 32'h0000_FC03
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;

  logic [31:0] srQ, srD;
  logic [31:0] epcQ, epcD;
  logic        bdQ, bdD;
  logic [5:0]  ipQ, ipD;
  logic [4:0]  excCodeQ, excCodeD;

  logic        intReq, excReq;
  logic [31:0] vpcAligned;

  assign intReq     = (|(hw_int & srQ[15:10])) & srQ[0] & ~srQ[1];
  assign excReq     = (exc_code_in != 5'd0) & ~srQ[1];
  // Held low during reset so a stale exc_code_in cannot flush the pipeline.
  assign req        = (intReq | excReq) & reset_n;
  assign vpcAligned = vpc & 32'hFFFF_FFFC;

  always_comb begin
    srD      = srQ;
    epcD     = epcQ;
    bdD      = bdQ;
    excCodeD = excCodeQ;
    ipD      = hw_int;
    if (req) begin
      // The faulting instruction is squashed: its mtc0 and any eret are dropped.
      srD[1]   = 1'b1;
      excCodeD = intReq ? 5'd0 : exc_code_in;
      bdD      = bd_in;
      epcD     = bd_in ? vpcAligned - 32'd4 : vpcAligned;
    end else begin
      if (en) begin
        unique case (cp0_addr)
          AddrSr:  srD  = cp0_in & SR_WMASK;
          AddrEpc: epcD = cp0_in & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (exl_clr) srD[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srQ      <= 32'd0;
      epcQ     <= 32'd0;
      bdQ      <= 1'b0;
      ipQ      <= 6'd0;
      excCodeQ <= 5'd0;
    end else begin
      srQ      <= srD;
      epcQ     <= epcD;
      bdQ      <= bdD;
      ipQ      <= ipD;
      excCodeQ <= excCodeD;
    end
  end

  always_comb begin
    cp0_out = 32'd0;
    unique case (cp0_addr)
      AddrSr:    cp0_out = srQ;
      AddrCause: cp0_out = {bdQ, 15'd0, ipQ, 3'd0, excCodeQ, 2'd0};
      AddrEpc:   cp0_out = epcQ;
      default:   cp0_out = 32'd0;
    endcase
  end

  assign epc_out    = epcQ;
  assign handler_pc = HANDLER_PC;

endmodule

// File: doc/m_cp0_exc.md
Name: m_cp0_exc

Overview:
- Coprocessor-0 unit at the M stage. It is the consumer end of the exception-code path that the E stage selects and pipelines forward.
- Takes the pipelined ExcCode, the victim PC, the branch-delay flag and the external interrupt lines.
- Decides whether to take an exception or interrupt, and holds the SR, Cause and EPC registers.
- Drives the flush/redirect request to the pipeline and the EPC used by eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, handler entry address, driven on handler_pc.
- SR_WMASK, 32'h0000_FC03, writable bits of SR: IM[15:10], EXL[1], IE[0].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  mtc0 write enable (M stage).
- cp0_addr  input  5  register select: 12 = SR, 13 = Cause, 14 = EPC.
- cp0_in  input  32  mtc0 write data.
- cp0_out  output  32  mfc0 read data; combinational; 0 for any other address.
- vpc  input  32  PC of the M-stage instruction (victim PC).
- bd_in  input  1  M-stage instruction is in a branch delay slot.
- exc_code_in  input  5  pipelined ExcCode; 0 = no exception.
- hw_int  input  6  external interrupt lines (level-sensitive).
- exl_clr  input  1  eret in M stage.
- req  output  1  take exception/interrupt this cycle; flush and redirect.
- epc_out  output  32  current EPC, used as the eret target.
- handler_pc  output  32  constant HANDLER_PC.

Behaviour:
- Reset (reset_n = 0, asynchronous): SR = 0, Cause = 0, EPC = 0.
  - req = 0, cp0_out = 0, epc_out = 0.
  - Release is synchronous to the next rising edge only for sampling. No state changes while reset_n = 0.
- Fields:
  - SR: IM = SR[15:10], EXL = SR[1], IE = SR[0].
  - Cause: BD = [31], IP = [15:10], ExcCode = [6:2].
  - All other bits read 0.
- int_req = (|(hw_int & IM)) & IE & ~EXL.
- exc_req = (exc_code_in != 0) & ~EXL.
- req = int_req | exc_req. Combinational, same cycle; zero latency to the pipeline.
- Priority: an interrupt beats an internal exception when both are present.
- Cause.IP <= hw_int on every edge, including cycles with a write or a req. It is never writable by mtc0.
- On an edge with req = 1, in one cycle:
  - EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2], 2'b00} - 4 : {vpc[31:2], 2'b00}.
  - The mtc0 write in the same cycle is discarded, because the instruction is squashed.
  - An exl_clr in the same cycle is also discarded.
- Otherwise, on an edge with en = 1:
  - SR write: SR <= cp0_in & SR_WMASK.
  - EPC write: EPC <= {cp0_in[31:2], 2'b00}.
  - Cause write: ignored.
  - Any other address: no effect.
- Otherwise, on an edge with exl_clr = 1: EXL <= 0.
- Same-cycle en (SR write) and exl_clr without req: the SR write is applied first, then EXL is forced to 0.
- Nesting: while EXL = 1, req stays 0 regardless of exc_code_in or hw_int. Pending interrupt lines are still reflected in IP.
- Read path:
  - cp0_out reflects register state before the current edge.
  - mfc0 in the same cycle as a write returns the old value.
  - epc_out = EPC.
- Arithmetic: EPC subtraction is 32-bit modulo. vpc = 0 with bd_in = 1 gives 32'hFFFF_FFFC.

Test Plan:
- Reset: reset_n = 0 mid-run after EPC = 32'h3010 was written -> all outputs 0 immediately, without waiting for a clock edge; after release cp0_out(14) = 0.
- Internal exception, not in a delay slot:
  - Stimulus: SR = 0, exc_code_in = 5'd12, vpc = 32'h3008, bd_in = 0.
  - Required: req = 1 in the same cycle.
  - Next cycle: EPC = 32'h3008, Cause.ExcCode = 12, EXL = 1, req = 0 even with exc_code_in held.
- Delay-slot exception: exc_code_in = 5'd4, vpc = 32'h300C, bd_in = 1 -> EPC = 32'h3008, Cause[31] = 1.
- Interrupt versus exception:
  - Stimulus: write SR = 32'h0000_0401 (IM[10] = 1, IE = 1); hw_int = 6'b000001 together with exc_code_in = 5'd10.
  - Required: req = 1; Cause.ExcCode = 0, Cause.IP = 6'b000001.
  - Masking: with hw_int = 6'b000010 instead, req = 0.
- Same-cycle mtc0 and req: en = 1, cp0_addr = 14, cp0_in = 32'h5000, exc_code_in = 5'd8, vpc = 32'h3020 -> EPC = 32'h3020, not 32'h5000.
- eret: with EXL = 1, exl_clr = 1 -> next cycle EXL = 0; epc_out is unchanged; a pending enabled hw_int now raises req in that cycle.
